// File: rtl/i2c_bus_scheduler_pkg.sv
// Shared types and constants for the I2C bus scheduler: FSM state encoding,
// default cycle counts at 50 MHz, and a counter-width helper.
package i2c_bus_scheduler_pkg;

  typedef enum logic [0:0] {
    ST_GAP    = 1'b0,
    ST_ACTIVE = 1'b1
  } sched_state_e;

  localparam int DEF_N_CLIENTS      = 2;
  localparam int DEF_GAP_CYCLES     = 50_000;     // 1 ms bus-idle gap
  localparam int DEF_TIMEOUT_CYCLES = 2_500_000;  // 50 ms forced release

  // Width needed to count 0..n-1; never zero so a GAP of 1 still gets a register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_bus_scheduler_rr_next_sel.sv
// Combinational round-robin picker: first eligible client after last_idx,
// wrapping around, with last_idx itself considered last.
module rr_next_sel #(
  parameter int N_CLIENTS = 2,
  parameter int IDX_W     = $clog2(N_CLIENTS)
) (
  input  logic [N_CLIENTS-1:0] mask,
  input  logic [IDX_W-1:0]     last_idx,
  output logic [IDX_W-1:0]     next_idx,
  output logic                 found
);

  logic [IDX_W-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest eligible client wins.
  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = N_CLIENTS; k >= 1; k--) begin
      cand = IDX_W'((int'(last_idx) + k) % N_CLIENTS);
      if (mask[cand]) begin
        next_idx = cand;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_scheduler.sv
// Shares one I2C SCL pin between several sensor masters. Each master is
// released in turn for one slot; the slot closes on the master's valid pulse
// or on timeout, and a fixed idle gap separates consecutive slots.
//
//   state     | meaning
//   ST_GAP    | bus idle, all masters held in reset, counting the idle gap
//   ST_ACTIVE | one master enabled and driving SCL until valid or timeout
module i2c_bus_scheduler
  import i2c_bus_scheduler_pkg::*;
#(
  parameter int   N_CLIENTS      = DEF_N_CLIENTS,
  parameter int   GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int   TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int  IDX_W          = $clog2(N_CLIENTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CLIENTS-1:0] client_mask,
  input  logic [N_CLIENTS-1:0] client_sclk,
  input  logic [N_CLIENTS-1:0] client_valid,
  output logic [N_CLIENTS-1:0] client_en,
  output logic                 I2C_SCLK,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 busy,
  output logic [N_CLIENTS-1:0] sample_strobe,
  output logic [N_CLIENTS-1:0] timeout_pulse
);

  localparam int GW = cnt_width(GAP_CYCLES);
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] SLOT_LAST = TW'(TIMEOUT_CYCLES - 1);

  sched_state_e         state_q;
  logic [GW-1:0]        gap_cnt_q;
  logic [TW-1:0]        slot_cnt_q;
  logic [IDX_W-1:0]     last_idx_q;
  logic [IDX_W-1:0]     grant_idx_q;
  logic [N_CLIENTS-1:0] client_en_q;
  logic                 busy_q;
  logic [N_CLIENTS-1:0] sample_strobe_q;
  logic [N_CLIENTS-1:0] timeout_pulse_q;

  logic [IDX_W-1:0]     next_idx_d;
  logic                 found_d;

  rr_next_sel #(
    .N_CLIENTS (N_CLIENTS),
    .IDX_W     (IDX_W)
  ) u_rr_next_sel (
    .mask     (client_mask),
    .last_idx (last_idx_q),
    .next_idx (next_idx_d),
    .found    (found_d)
  );

  // Slot scheduler: idle gap, round-robin grant, close on valid or timeout.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= ST_GAP;
      gap_cnt_q       <= '0;
      slot_cnt_q      <= '0;
      last_idx_q      <= IDX_W'(N_CLIENTS - 1);
      grant_idx_q     <= '0;
      client_en_q     <= '0;
      busy_q          <= 1'b0;
      sample_strobe_q <= '0;
      timeout_pulse_q <= '0;
    end else begin
      sample_strobe_q <= '0;
      timeout_pulse_q <= '0;
      case (state_q)
        ST_GAP: begin
          client_en_q <= '0;
          busy_q      <= 1'b0;
          if (gap_cnt_q == GAP_LAST) begin
            // An empty mask restarts the gap so the mask is re-read one gap later.
            gap_cnt_q <= '0;
            if (found_d) begin
              grant_idx_q <= next_idx_d;
              last_idx_q  <= next_idx_d;
              client_en_q <= N_CLIENTS'(1) << next_idx_d;
              busy_q      <= 1'b1;
              slot_cnt_q  <= '0;
              state_q     <= ST_ACTIVE;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        ST_ACTIVE: begin
          // Valid takes priority over a coincident timeout.
          if (client_valid[grant_idx_q]) begin
            sample_strobe_q[grant_idx_q] <= 1'b1;
            client_en_q <= '0;
            busy_q      <= 1'b0;
            gap_cnt_q   <= '0;
            state_q     <= ST_GAP;
          end else if (slot_cnt_q == SLOT_LAST) begin
            timeout_pulse_q[grant_idx_q] <= 1'b1;
            client_en_q <= '0;
            busy_q      <= 1'b0;
            gap_cnt_q   <= '0;
            state_q     <= ST_GAP;
          end else begin
            slot_cnt_q <= slot_cnt_q + TW'(1);
          end
        end
        default: begin
          client_en_q <= '0;
          busy_q      <= 1'b0;
          gap_cnt_q   <= '0;
          state_q     <= ST_GAP;
        end
      endcase
    end
  end

  // SCL follows the granted master only while a slot is open; idle level is high.
  always_comb begin
    I2C_SCLK = busy_q ? client_sclk[grant_idx_q] : 1'b1;
  end

  assign client_en     = client_en_q;
  assign grant_idx     = grant_idx_q;
  assign busy          = busy_q;
  assign sample_strobe = sample_strobe_q;
  assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_i2c_bus_scheduler.sv
// Bench for i2c_bus_scheduler: a slot-level model predicts every output each
// cycle, and directed scenarios pin the model with hand-computed values.
module tb_i2c_bus_scheduler;

  localparam int N  = 2;
  localparam int GP = 4;
  localparam int TO = 20;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] client_mask = 2'b11;
  logic [N-1:0] client_sclk = 2'b00;
  logic [N-1:0] client_valid = 2'b00;
  logic [N-1:0] client_en;
  logic         I2C_SCLK;
  logic [0:0]   grant_idx;
  logic         busy;
  logic [N-1:0] sample_strobe;
  logic [N-1:0] timeout_pulse;

  int errors = 0;
  int checks = 0;

  i2c_bus_scheduler #(
    .N_CLIENTS      (N),
    .GAP_CYCLES     (GP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .client_mask   (client_mask),
    .client_sclk   (client_sclk),
    .client_valid  (client_valid),
    .client_en     (client_en),
    .I2C_SCLK      (I2C_SCLK),
    .grant_idx     (grant_idx),
    .busy          (busy),
    .sample_strobe (sample_strobe),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- slot-level model ----------------
  bit           started = 1'b0;
  bit           m_busy = 1'b0;
  int           m_grant = 0;
  int           m_last = N - 1;
  int           m_idle = 0;   // idle cycles elapsed in the current gap
  int           m_age = 0;    // slot cycles elapsed
  logic [N-1:0] m_en = '0;
  logic [N-1:0] m_strobe = '0;
  logic [N-1:0] m_tout = '0;

  function automatic int rr_pick(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++) begin
      if (m[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (!reset) begin
      m_busy = 0; m_grant = 0; m_last = N - 1; m_idle = 0; m_age = 0;
      m_en = '0; m_strobe = '0; m_tout = '0;
    end else begin
      m_strobe = '0;
      m_tout   = '0;
      if (!m_busy) begin
        m_idle++;
        if (m_idle == GP) begin
          int p;
          m_idle = 0;
          p = rr_pick(client_mask, m_last);
          if (p >= 0) begin
            m_grant = p; m_last = p; m_busy = 1; m_age = 0;
            m_en = '0;
            m_en[p] = 1'b1;
          end
        end
      end else begin
        m_age++;
        if (client_valid[m_grant]) begin
          m_strobe[m_grant] = 1'b1;
          m_busy = 0; m_en = '0; m_idle = 0;
        end else if (m_age == TO) begin
          m_tout[m_grant] = 1'b1;
          m_busy = 0; m_en = '0; m_idle = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      chk("client_en",     client_en,     m_en);
      chk("busy",          busy,          m_busy);
      chk("grant_idx",     grant_idx,     m_grant);
      chk("sample_strobe", sample_strobe, m_strobe);
      chk("timeout_pulse", timeout_pulse, m_tout);
      chk("I2C_SCLK",      I2C_SCLK,      m_busy ? client_sclk[m_grant] : 1'b1);
      chk("en_onehot0",    $onehot0(client_en), 1'b1);
    end
  end

  // Free-running SCL activity from the masters so the pin mux is exercised.
  initial begin
    forever begin
      @(posedge clk);
      #1 client_sclk = N'($urandom_range(0, 3));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    // 1: release reset with both clients eligible
    reset = 1'b0; client_mask = 2'b11;
    step(3);
    chk("rst_en", client_en, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_idx, 0);
    reset = 1'b1;
    step(3);
    chk("t1_en_early", client_en, 2'b00);
    step(1);
    chk("t1_en", client_en, 2'b01);
    chk("t1_grant", grant_idx, 0);
    chk("t1_busy", busy, 1'b1);

    // 2: valid from client 0 at slot cycle 7
    step(7);
    client_valid = 2'b01;
    step(1);
    client_valid = 2'b00;
    chk("t2_strobe", sample_strobe, 2'b01);
    chk("t2_en_off", client_en, 2'b00);
    step(3);
    chk("t2_gap_en", client_en, 2'b00);
    step(1);
    chk("t2_en_next", client_en, 2'b10);
    chk("t2_grant", grant_idx, 1);

    // 3: client 1 never answers
    step(19);
    chk("t3_en_hold", client_en, 2'b10);
    chk("t3_no_tout", timeout_pulse, 2'b00);
    step(1);
    chk("t3_tout", timeout_pulse, 2'b10);
    chk("t3_no_strobe", sample_strobe, 2'b00);
    chk("t3_en_off", client_en, 2'b00);
    step(4);
    chk("t3_wrap_en", client_en, 2'b01);
    chk("t3_wrap_grant", grant_idx, 0);

    // 5: foreign valid ignored, valid on the timeout cycle wins
    step(2);
    client_valid = 2'b10;
    step(1);
    client_valid = 2'b00;
    chk("t5_foreign", sample_strobe, 2'b00);
    chk("t5_en_hold", client_en, 2'b01);
    step(16);
    client_valid = 2'b01;
    step(1);
    client_valid = 2'b00;
    chk("t5_strobe", sample_strobe, 2'b01);
    chk("t5_no_tout", timeout_pulse, 2'b00);
    chk("t5_en_off", client_en, 2'b00);

    // 4: only client 1 eligible, then nobody
    client_mask = 2'b10;
    step(4);
    chk("t4_en_a", client_en, 2'b10);
    step(20);
    chk("t4_tout_a", timeout_pulse, 2'b10);
    step(4);
    chk("t4_en_b", client_en, 2'b10);
    chk("t4_grant_b", grant_idx, 1);
    step(19);
    client_mask = 2'b00;
    chk("t4_mask_noabort", client_en, 2'b10);
    step(1);
    chk("t4_tout_b", timeout_pulse, 2'b10);
    for (int i = 0; i < 100; i++) begin
      step(1);
      chk("t4_idle_busy", busy, 1'b0);
      chk("t4_idle_sclk", I2C_SCLK, 1'b1);
    end

    // 6: reset in the middle of a slot
    client_mask = 2'b11;
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    step(4);
    chk("t6_en", client_en, 2'b01);
    step(5);
    reset = 1'b0;
    step(1);
    chk("t6_rst_en", client_en, 2'b00);
    chk("t6_rst_busy", busy, 1'b0);
    reset = 1'b1;
    step(3);
    chk("t6_gap_en", client_en, 2'b00);
    step(1);
    chk("t6_regrant", client_en, 2'b01);
    chk("t6_regrant_idx", grant_idx, 0);
    step(25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
